// File: rtl/mig_req_ctrl.sv
// mig_req_ctrl: issues single-beat reads/writes on a MIG app interface and returns tagged read data in order under a credit limit
module mig_req_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DWIDTH     = 128,
  parameter int TAG_WIDTH  = 4,
  parameter int OUTS_BITS  = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_cmd,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0]     req_data,
  input  logic [DWIDTH/8-1:0]   req_mask,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DWIDTH-1:0]     rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  init_calib_complete,
  output logic [ADDR_WIDTH-1:0] app_addr,
  output logic [2:0]            app_cmd,
  output logic                  app_en,
  input  logic                  app_rdy,
  output logic [DWIDTH-1:0]     app_wdf_data,
  output logic [DWIDTH/8-1:0]   app_wdf_mask,
  output logic                  app_wdf_wren,
  output logic                  app_wdf_end,
  input  logic                  app_wdf_rdy,
  input  logic [DWIDTH-1:0]     app_rd_data,
  input  logic                  app_rd_data_valid,
  input  logic                  app_rd_data_end,
  output logic                  err_unexp_rd
);
  localparam int DEPTH = 1 << OUTS_BITS;
  localparam int CW = OUTS_BITS + 1;
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_WR_BOTH, S_WR_CMD, S_WR_DATA} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [TAG_WIDTH-1:0] hold_tag_q, hold_tag_d;
  logic app_en_q, app_en_d, app_wdf_wren_q, app_wdf_wren_d, err_q, err_d;
  logic [2:0] app_cmd_q, app_cmd_d;
  logic [ADDR_WIDTH-1:0] app_addr_q, app_addr_d;
  logic [DWIDTH-1:0] app_wdf_data_q, app_wdf_data_d;
  logic [DWIDTH/8-1:0] app_wdf_mask_q, app_wdf_mask_d;
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [TAG_WIDTH+DWIDTH-1:0] rsp_mem [DEPTH];
  logic [OUTS_BITS-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d, rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [CW-1:0] tag_cnt_q, tag_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic accept, tag_push, rd_hit, rsp_pop;
  logic unused_end;
  assign unused_end = app_rd_data_end;
  assign req_ready = (state_q == S_IDLE) && (credits_q != '0);
  assign accept = req_valid && req_ready;
  assign tag_push = (state_q == S_RD) && app_rdy;
  assign rd_hit = app_rd_data_valid && (tag_cnt_q != '0);
  assign rsp_valid = rsp_cnt_q != '0;
  assign rsp_pop = rsp_valid && rsp_ready;
  assign {rsp_tag, rsp_data} = rsp_valid ? rsp_mem[rsp_rd_q] : '0;
  assign app_en = app_en_q;
  assign app_cmd = app_cmd_q;
  assign app_addr = app_addr_q;
  assign app_wdf_data = app_wdf_data_q;
  assign app_wdf_mask = app_wdf_mask_q;
  assign app_wdf_wren = app_wdf_wren_q;
  assign app_wdf_end = app_wdf_wren_q;
  assign err_unexp_rd = err_q;
  always_comb begin
    state_d = state_q;
    hold_tag_d = hold_tag_q;
    app_en_d = app_en_q;
    app_cmd_d = app_cmd_q;
    app_addr_d = app_addr_q;
    app_wdf_wren_d = app_wdf_wren_q;
    app_wdf_data_d = app_wdf_data_q;
    app_wdf_mask_d = app_wdf_mask_q;
    case (state_q)
      S_INIT: state_d = init_calib_complete ? S_IDLE : S_INIT;
      S_IDLE: if (accept) begin
        state_d = req_cmd ? S_RD : S_WR_BOTH;
        hold_tag_d = req_tag;
        app_en_d = 1'b1;
        app_cmd_d = req_cmd ? 3'b001 : 3'b000;
        app_addr_d = req_addr;
        app_wdf_wren_d = !req_cmd;
        app_wdf_data_d = req_cmd ? app_wdf_data_q : req_data;
        app_wdf_mask_d = req_cmd ? app_wdf_mask_q : req_mask;
      end
      S_RD: if (app_rdy) begin
        state_d = S_IDLE;
        app_en_d = 1'b0;
      end
      S_WR_BOTH: begin
        app_en_d = !app_rdy;
        app_wdf_wren_d = !app_wdf_rdy;
        state_d = (app_rdy && app_wdf_rdy) ? S_IDLE :
                  app_rdy ? S_WR_DATA :
                  app_wdf_rdy ? S_WR_CMD : S_WR_BOTH;
      end
      S_WR_CMD: if (app_rdy) begin
        state_d = S_IDLE;
        app_en_d = 1'b0;
      end
      S_WR_DATA: if (app_wdf_rdy) begin
        state_d = S_IDLE;
        app_wdf_wren_d = 1'b0;
      end
      default: state_d = S_INIT;
    endcase
  end
  // credits cover reserved, in-flight and buffered reads, so the response FIFO cannot overflow
  always_comb begin
    credits_d = credits_q - CW'(accept && req_cmd) + CW'(rsp_pop);
    tag_wr_d = tag_push ? tag_wr_q + 1'b1 : tag_wr_q;
    tag_rd_d = rd_hit ? tag_rd_q + 1'b1 : tag_rd_q;
    tag_cnt_d = tag_cnt_q + CW'(tag_push) - CW'(rd_hit);
    rsp_wr_d = rd_hit ? rsp_wr_q + 1'b1 : rsp_wr_q;
    rsp_rd_d = rsp_pop ? rsp_rd_q + 1'b1 : rsp_rd_q;
    rsp_cnt_d = rsp_cnt_q + CW'(rd_hit) - CW'(rsp_pop);
    err_d = err_q || (app_rd_data_valid && (tag_cnt_q == '0));
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_INIT;
      credits_q <= CW'(DEPTH);
      hold_tag_q <= '0;
      app_en_q <= 1'b0;
      app_cmd_q <= '0;
      app_addr_q <= '0;
      app_wdf_wren_q <= 1'b0;
      app_wdf_data_q <= '0;
      app_wdf_mask_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      tag_cnt_q <= '0;
      rsp_wr_q <= '0;
      rsp_rd_q <= '0;
      rsp_cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credits_q <= credits_d;
      hold_tag_q <= hold_tag_d;
      app_en_q <= app_en_d;
      app_cmd_q <= app_cmd_d;
      app_addr_q <= app_addr_d;
      app_wdf_wren_q <= app_wdf_wren_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_wdf_mask_q <= app_wdf_mask_d;
      tag_wr_q <= tag_wr_d;
      tag_rd_q <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
      rsp_wr_q <= rsp_wr_d;
      rsp_rd_q <= rsp_rd_d;
      rsp_cnt_q <= rsp_cnt_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge sys_clk) begin
    if (tag_push) tag_mem[tag_wr_q] <= hold_tag_q;
    if (rd_hit) rsp_mem[rsp_wr_q] <= {tag_mem[tag_rd_q], app_rd_data};
  end
endmodule

// File: tb/tb_mig_req_ctrl.sv
// tb_mig_req_ctrl: directed self-checking bench for mig_req_ctrl
module tb_mig_req_ctrl;
  logic sys_clk = 1'b0, sys_rst_n;
  logic req_valid, req_ready, req_cmd;
  logic [11:0] req_addr, app_addr;
  logic [127:0] req_data, rsp_data, app_wdf_data, app_rd_data;
  logic [15:0] req_mask, app_wdf_mask;
  logic [3:0] req_tag, rsp_tag;
  logic rsp_valid, rsp_ready, init_calib_complete;
  logic [2:0] app_cmd;
  logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic app_rd_data_valid, app_rd_data_end, err_unexp_rd;
  int checks = 0, passes = 0;
  mig_req_ctrl dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_data(req_data), .req_mask(req_mask), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .err_unexp_rd(err_unexp_rd)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic do_read(input logic [11:0] a, input logic [3:0] t);
    req_valid = 1'b1; req_cmd = 1'b1; req_addr = a; req_tag = t;
    tick();
    req_valid = 1'b0;
    checks++; if (app_en !== 1'b1 || app_cmd !== 3'b001 || app_addr !== a) $display("FAIL rd_issue: en=%b cmd=%b addr=%h want en=1 cmd=001 addr=%h", app_en, app_cmd, app_addr, a); else passes++;
    app_rdy = 1'b1;
    tick();
    app_rdy = 1'b0;
  endtask
  task automatic rd_return(input logic [127:0] d);
    app_rd_data = d; app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
  endtask
  task automatic pop_chk(input logic [3:0] t, input logic [127:0] d);
    checks++; if (rsp_valid !== 1'b1 || rsp_tag !== t || rsp_data !== d) $display("FAIL rsp: valid=%b tag=%h data=%h want valid=1 tag=%h data=%h", rsp_valid, rsp_tag, rsp_data, t, d); else passes++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset();
    sys_rst_n = 1'b0; req_valid = 1'b0; req_cmd = 1'b0; req_addr = '0; req_data = '0; req_mask = '0; req_tag = '0;
    rsp_ready = 1'b0; init_calib_complete = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
    tick(); tick();
    checks++; if ({req_ready, rsp_valid, app_en, app_wdf_wren, app_wdf_end, err_unexp_rd} !== 6'b0) $display("FAIL reset_ctl: got %b want 000000", {req_ready, rsp_valid, app_en, app_wdf_wren, app_wdf_end, err_unexp_rd}); else passes++;
    checks++; if (app_addr !== 12'h0 || app_cmd !== 3'b0 || app_wdf_data !== 128'h0 || app_wdf_mask !== 16'h0) $display("FAIL reset_app: addr=%h cmd=%b data=%h mask=%h want all 0", app_addr, app_cmd, app_wdf_data, app_wdf_mask); else passes++;
    checks++; if (rsp_data !== 128'h0 || rsp_tag !== 4'h0) $display("FAIL reset_rsp: data=%h tag=%h want 0", rsp_data, rsp_tag); else passes++;
    checks++; if (dut.credits_q !== 4'd8) $display("FAIL reset_credits: got %0d want 8", dut.credits_q); else passes++;
    sys_rst_n = 1'b1;
  endtask
  task automatic test_init();
    req_valid = 1'b1; req_cmd = 1'b1; req_addr = 12'h7; req_tag = 4'h7;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (req_ready !== 1'b0 || app_en !== 1'b0) $display("FAIL init_wait: cyc %0d ready=%b en=%b want 0 0", i, req_ready, app_en); else passes++;
    end
    req_valid = 1'b0; init_calib_complete = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) $display("FAIL init_ready: got %b want 1", req_ready); else passes++;
  endtask
  task automatic test_write();
    req_valid = 1'b1; req_cmd = 1'b0; req_addr = 12'h010; req_data = {16{8'hA5}}; req_mask = '0;
    app_wdf_rdy = 1'b1; app_rdy = 1'b0;
    tick();
    req_valid = 1'b0;
    checks++; if (app_en !== 1'b1 || app_cmd !== 3'b000 || app_addr !== 12'h010) $display("FAIL wr_cmd: en=%b cmd=%b addr=%h want 1 000 010", app_en, app_cmd, app_addr); else passes++;
    checks++; if (app_wdf_wren !== 1'b1 || app_wdf_end !== 1'b1 || app_wdf_data !== {16{8'hA5}} || app_wdf_mask !== 16'h0) $display("FAIL wr_data: wren=%b end=%b data=%h mask=%h want 1 1 a5.. 0", app_wdf_wren, app_wdf_end, app_wdf_data, app_wdf_mask); else passes++;
    checks++; if (req_ready !== 1'b0) $display("FAIL wr_busy: ready=%b want 0", req_ready); else passes++;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (app_wdf_wren !== 1'b0 || app_en !== 1'b1 || app_cmd !== 3'b000 || app_addr !== 12'h010) $display("FAIL wr_hold: cyc %0d wren=%b en=%b cmd=%b addr=%h want 0 1 000 010", i, app_wdf_wren, app_en, app_cmd, app_addr); else passes++;
    end
    app_rdy = 1'b1;
    tick();
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    checks++; if (app_en !== 1'b0 || req_ready !== 1'b1) $display("FAIL wr_done: en=%b ready=%b want 0 1", app_en, req_ready); else passes++;
  endtask
  task automatic test_wr_data_wait();
    req_valid = 1'b1; req_cmd = 1'b0; req_addr = 12'h020; req_data = 128'h1234; req_mask = 16'h00F0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    app_rdy = 1'b0;
    checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b1 || app_wdf_mask !== 16'h00F0 || app_wdf_data !== 128'h1234) $display("FAIL wrd_hold: en=%b wren=%b mask=%h data=%h want 0 1 00f0 1234", app_en, app_wdf_wren, app_wdf_mask, app_wdf_data); else passes++;
    app_wdf_rdy = 1'b1;
    tick();
    app_wdf_rdy = 1'b0;
    checks++; if (app_wdf_wren !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL wrd_done: wren=%b ready=%b rsp_valid=%b want 0 1 0", app_wdf_wren, req_ready, rsp_valid); else passes++;
  endtask
  task automatic test_reads();
    do_read(12'h001, 4'h1);
    do_read(12'h002, 4'h2);
    do_read(12'h003, 4'h3);
    tick();
    rd_return(128'h11);
    rd_return(128'h22);
    rd_return(128'h33);
    pop_chk(4'h1, 128'h11);
    pop_chk(4'h2, 128'h22);
    pop_chk(4'h3, 128'h33);
    checks++; if (rsp_valid !== 1'b0 || dut.credits_q !== 4'd8) $display("FAIL rd_drain: valid=%b credits=%0d want 0 8", rsp_valid, dut.credits_q); else passes++;
  endtask
  task automatic test_credits();
    for (int i = 0; i < 8; i++) do_read(12'(i + 16), 4'(i));
    for (int i = 0; i < 8; i++) rd_return(128'(32'hC0DE_0000 + i));
    req_valid = 1'b1; req_cmd = 1'b1; req_addr = 12'h099; req_tag = 4'h9;
    tick();
    checks++; if (req_ready !== 1'b0 || app_en !== 1'b0) $display("FAIL cred_full: ready=%b en=%b want 0 0", req_ready, app_en); else passes++;
    checks++; if (dut.credits_q !== 4'd0) $display("FAIL cred_zero: got %0d want 0", dut.credits_q); else passes++;
    pop_chk(4'h0, 128'hC0DE_0000);
    checks++; if (req_ready !== 1'b1 || dut.credits_q !== 4'd1) $display("FAIL cred_back: ready=%b credits=%0d want 1 1", req_ready, dut.credits_q); else passes++;
    req_valid = 1'b0;
    for (int i = 1; i < 8; i++) pop_chk(4'(i), 128'(32'hC0DE_0000 + i));
    checks++; if (rsp_valid !== 1'b0 || dut.credits_q !== 4'd8) $display("FAIL cred_drain: valid=%b credits=%0d want 0 8", rsp_valid, dut.credits_q); else passes++;
  endtask
  task automatic test_unexp_rd();
    checks++; if (err_unexp_rd !== 1'b0) $display("FAIL unexp_pre: got %b want 0", err_unexp_rd); else passes++;
    rd_return(128'hDEAD);
    checks++; if (err_unexp_rd !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL unexp_set: err=%b rsp_valid=%b want 1 0", err_unexp_rd, rsp_valid); else passes++;
    tick(); tick();
    checks++; if (err_unexp_rd !== 1'b1 || rsp_valid !== 1'b0 || dut.credits_q !== 4'd8) $display("FAIL unexp_sticky: err=%b rsp_valid=%b credits=%0d want 1 0 8", err_unexp_rd, rsp_valid, dut.credits_q); else passes++;
  endtask
  task automatic test_reset_mid();
    req_valid = 1'b1; req_cmd = 1'b0; req_addr = 12'h030; req_data = 128'hBEEF; req_mask = '0;
    app_wdf_rdy = 1'b1; app_rdy = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    app_wdf_rdy = 1'b0;
    checks++; if (app_en !== 1'b1 || app_wdf_wren !== 1'b0) $display("FAIL mid_wrcmd: en=%b wren=%b want 1 0", app_en, app_wdf_wren); else passes++;
    sys_rst_n = 1'b0;
    #1;
    checks++; if (app_en !== 1'b0 || app_wdf_wren !== 1'b0 || err_unexp_rd !== 1'b0) $display("FAIL mid_async: en=%b wren=%b err=%b want 0 0 0", app_en, app_wdf_wren, err_unexp_rd); else passes++;
    init_calib_complete = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick(); tick();
    checks++; if (req_ready !== 1'b0 || app_en !== 1'b0 || dut.credits_q !== 4'd8) $display("FAIL mid_init: ready=%b en=%b credits=%0d want 0 0 8", req_ready, app_en, dut.credits_q); else passes++;
    init_calib_complete = 1'b1;
    tick();
    checks++; if (req_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", req_ready); else passes++;
  endtask
  initial begin
    test_reset();
    test_init();
    test_write();
    test_wr_data_wait();
    test_reads();
    test_credits();
    test_unexp_rd();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mig_req_ctrl.md
Name: mig_req_ctrl

Overview:
- Request-side controller that drives the MIG-style application interface. The interface is either the real DDR MIG or the DPRAM-backed emulation wrapper.
- Accepts single-beat read/write requests from the KV lookup/update pipeline, issues them with correct app_rdy/app_wdf_rdy handshaking, and returns read data in order with the requester's tag.
- Bounds outstanding reads with a credit scheme, because MIG read data cannot be back-pressured.

Parameters:
- ADDR_WIDTH, 12, width of req_addr/app_addr.
- DWIDTH, 128, data width per beat; mask width is DWIDTH/8.
- TAG_WIDTH, 4, opaque requester tag width.
- OUTS_BITS, 3, log2 of maximum outstanding reads; this is also the depth of the tag FIFO and the response FIFO (8).

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_cmd  in  1  0=write, 1=read.
- req_addr  in  ADDR_WIDTH  target address.
- req_data  in  DWIDTH  write data.
- req_mask  in  DWIDTH/8  write byte mask (1=byte not written).
- req_tag  in  TAG_WIDTH  tag returned with the read response.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer takes response.
- rsp_data  out  DWIDTH  read data.
- rsp_tag  out  TAG_WIDTH  tag of that read.
- init_calib_complete  in  1  memory ready.
- app_addr  out  ADDR_WIDTH  command address.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_en  out  1  command valid.
- app_rdy  in  1  command accepted when high with app_en.
- app_wdf_data  out  DWIDTH  write data.
- app_wdf_mask  out  DWIDTH/8  write mask.
- app_wdf_wren  out  1  write data valid.
- app_wdf_end  out  1  equals app_wdf_wren (single beat).
- app_wdf_rdy  in  1  write data accepted when high with app_wdf_wren.
- app_rd_data  in  DWIDTH  read data.
- app_rd_data_valid  in  1  read data strobe.
- app_rd_data_end  in  1  ignored (single beat).
- err_unexp_rd  out  1  sticky: read data arrived with no read outstanding.

Behaviour:
- Reset (async, sys_rst_n=0): state=S_INIT. All outputs go to 0: req_ready, rsp_valid, app_en, app_wdf_wren, app_wdf_end, app_addr, app_cmd, app_wdf_data/mask, rsp_data, rsp_tag and err_unexp_rd. Both FIFOs are empty and credits = 2^OUTS_BITS. If reset is asserted mid-operation, any held request is discarded; the bench must not expect it to complete.
- FSM states:
  - S_INIT: waits for init_calib_complete=1, then goes to S_IDLE. It stays in S_INIT until then, with req_ready=0.
  - S_IDLE: req_ready = (credits != 0), independent of req_cmd. On req_valid&&req_ready, the request is captured into the holding register.
    - Read: credits decrement; next state S_RD.
    - Write: next state S_WR_BOTH.
  - S_RD: app_en=1, app_cmd=001, app_addr=held address. On app_rdy, req_tag is pushed into the tag FIFO and the FSM returns to S_IDLE.
  - S_WR_BOTH: app_en=1 with cmd 000, and app_wdf_wren=app_wdf_end=1 with the held data and mask.
    - app_rdy&&app_wdf_rdy: go to S_IDLE.
    - app_rdy only: go to S_WR_DATA.
    - app_wdf_rdy only: go to S_WR_CMD.
  - S_WR_CMD: app_en held high until app_rdy, then S_IDLE.
  - S_WR_DATA: app_wdf_wren held high until app_wdf_rdy, then S_IDLE.
- All app_* outputs are registered. Each app_* output changes only on state entry or on acceptance, so it stays stable while waiting.
- Minimum request spacing is 2 cycles (accept in S_IDLE, issue next cycle). Issue latency from req acceptance to app_en=1 is 1 cycle.
- Read return:
  - On app_rd_data_valid, pop the tag FIFO and push {tag, app_rd_data} into the response FIFO.
  - The response FIFO is first-word-fall-through: rsp_valid = !empty, and rsp_data/rsp_tag show the head entry.
  - On rsp_valid&&rsp_ready, pop the entry and increment credits.
  - A simultaneous credit increment and decrement leaves credits unchanged.
  - Credits span reserved + in-flight + buffered reads, so the response FIFO never overflows.
- If app_rd_data_valid arrives with the tag FIFO empty, the data is dropped, err_unexp_rd is set to 1 and stays set until reset, and no FIFO changes.
- Ordering: responses are returned strictly in read-issue order. Writes generate no response.
- credits is OUTS_BITS+1 bits wide and never exceeds 2^OUTS_BITS.

Test Plan:
1. init_calib_complete=0 for 20 cycles with req_valid=1 -> req_ready=0 and app_en=0 throughout; set calib=1 -> req_ready=1 on the next cycle.
2. Write addr=0x010, data=0xA5..A5, mask=0, with app_wdf_rdy=1 and app_rdy held 0 for 3 cycles -> app_wdf_wren pulses for exactly 1 cycle. app_en stays high with app_cmd=000 and app_addr=0x010 until app_rdy; then req_ready=1.
3. Three reads with tags 1, 2, 3 to addrs 0x001–0x003. The memory model returns data 0x11, 0x22, 0x33 with latency 5 -> rsp_tag sequence 1, 2, 3 with matching data.
4. rsp_ready=0, 8 reads issued -> 9th request sees req_ready=0. Pop one response -> req_ready=1 on the following cycle, with the credit count returned to 1.
5. app_rd_data_valid pulse with no read outstanding -> err_unexp_rd=1 sticky, rsp_valid stays 0.
6. Assert sys_rst_n=0 while in S_WR_CMD -> app_en=0, app_wdf_wren=0 immediately (async). After release, FSM is in S_INIT and credits=8.
